// File: rtl/bus_arbiter.sv
// Two-master bus arbiter placed directly upstream of the address decoder.
// Master 0 is the parked default owner; ownership passes to master 1 only
// when master 0 is idle, and returns to master 0 once master 1 goes idle.
// The granted master's request, write enable, address and write data are
// muxed combinationally onto the shared bus from the registered grant.
// Optional feature macro: BUS_ARB_TIMEOUT_EN. When defined, a hold counter
// forces a handover after MAX_HOLD contested cycles, in either direction.
module bus_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              s_req,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_wdata
);

    // The hold limit must fit in the counter and leave room for a count.
    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("bus_arbiter: MAX_HOLD out of range for CNT_W");
    end

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_t;

    state_t state_q, state_d;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             contested;
    logic             expired;

    // Contention is the owner still requesting while the other master waits.
    always_comb begin
        contested = m0_req & m1_req;
        expired   = contested && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    end

    // Count contested cycles; any grant change or released contention clears.
    always_comb begin
        hold_cnt_d = '0;
        if (contested && !expired) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // State register; reset parks the bus on master 0 immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= M0_GRANT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: handover when the owner idles, master 1 always returns home.
    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: begin
                if (!m0_req && m1_req) begin
                    state_d = M1_GRANT;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                if (expired) begin
                    state_d = M1_GRANT;
                end
`endif
            end
            M1_GRANT: begin
                if (!m1_req) begin
                    state_d = M0_GRANT;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                if (expired) begin
                    state_d = M0_GRANT;
                end
`endif
            end
            default: state_d = M0_GRANT;
        endcase
    end

    // Moore grant decode and pass-through mux of the owner's bus signals.
    always_comb begin
        m0_grant = (state_q == M0_GRANT);
        m1_grant = ~m0_grant;
        if (m0_grant) begin
            s_req     = m0_req;
            s_wr      = m0_wr;
            s_address = m0_address;
            s_wdata   = m0_dout;
        end else begin
            s_req     = m1_req;
            s_wr      = m1_wr;
            s_address = m1_address;
            s_wdata   = m1_dout;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed table, hand sequences for
// reset, long contention and park, then randomized traffic against an
// ownership model. Follows BUS_ARB_TIMEOUT_EN if the build defines it.
module tb_bus_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_dout, m1_dout;
    logic              m0_grant, m1_grant, s_req, s_wr;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus and how long the wait has lasted.
    int owner     = 0;
    int contested = 0;

    bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
        .m0_grant(m0_grant), .m1_grant(m1_grant), .s_req(s_req), .s_wr(s_wr),
        .s_address(s_address), .s_wdata(s_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              r0;
        logic              r1;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              exp_m1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership rules applied to the request pair seen at a clock edge.
    task automatic model_edge(input logic r0, input logic r1);
        bit both;
        both = r0 && r1;
        if (owner == 0 && !r0 && r1) owner = 1;
        else if (owner == 1 && !r1) owner = 0;
        else if (TIMEOUT && both) begin
            contested++;
            if (contested == MAX_HOLD) begin
                owner = 1 - owner;
                contested = 0;
            end
            return;
        end
        contested = 0;
    endtask

    task automatic check_bus(input string tag);
        chk({tag, ".m0_grant"}, 64'(m0_grant), 64'(owner == 0));
        chk({tag, ".m1_grant"}, 64'(m1_grant), 64'(owner == 1));
        chk({tag, ".s_req"}, 64'(s_req), 64'(owner == 1 ? m1_req : m0_req));
        chk({tag, ".s_wr"}, 64'(s_wr), 64'(owner == 1 ? m1_wr : m0_wr));
        chk({tag, ".s_address"}, 64'(s_address), 64'(owner == 1 ? m1_address : m0_address));
        chk({tag, ".s_wdata"}, 64'(s_wdata), 64'(owner == 1 ? m1_dout : m0_dout));
    endtask

    // Apply requests, clock once, advance the model and compare.
    task automatic step(input logic r0, input logic r1, input string tag);
        m0_req = r0;
        m1_req = r1;
        @(posedge clk);
        #1;
        model_edge(r0, r1);
        check_bus(tag);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h05, 8'h25, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h05, 8'h25, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h05, 8'h25, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h05, 8'h25, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h05, 8'h3A, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h05, 8'h3A, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 8'h05, 8'h3A, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'h05, 8'h3A, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h05, 8'h3A, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 8'h05, 8'h3A, 1'b0};

        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b1; m1_wr = 1'b0;
        m0_address = 8'h05; m1_address = 8'h25;
        m0_dout = 32'hA0A0_0000; m1_dout = 32'hB1B1_1111;
        #2;
        chk("reset.m0_grant", 64'(m0_grant), 64'd1);
        chk("reset.m1_grant", 64'(m1_grant), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        owner = 0; contested = 0;

        // Directed table: handover, return home, no preemption, park.
        foreach (tbl[i]) begin
            m0_address = tbl[i].a0;
            m1_address = tbl[i].a1;
            m0_wr = tbl[i].r0;
            m1_wr = ~tbl[i].r0;
            m0_dout = 32'h1000 + i;
            m1_dout = 32'h2000 + i;
            step(tbl[i].r0, tbl[i].r1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_m1", i), 64'(m1_grant), 64'(tbl[i].exp_m1));
            chk($sformatf("tbl%0d.addr", i), 64'(s_address),
                64'(tbl[i].exp_m1 ? tbl[i].a1 : tbl[i].a0));
            chk($sformatf("tbl%0d.sel", i), 64'(s_address[7:5]),
                64'(tbl[i].exp_m1 ? tbl[i].a1[7:5] : tbl[i].a0[7:5]));
        end

        // Asynchronous reset mid-tenure of master 1.
        step(1'b0, 1'b1, "pre_rst");
        chk("pre_rst.m1_grant", 64'(m1_grant), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst.m0_grant", 64'(m0_grant), 64'd1);
        chk("async_rst.m1_grant", 64'(m1_grant), 64'd0);
        owner = 0; contested = 0;
        m1_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b0, "post_rst");
        chk("post_rst.m0_grant", 64'(m0_grant), 64'd1);

        // Sustained contention from a fresh master 0 tenure.
        step(1'b1, 1'b0, "cont_pre");
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b1, $sformatf("cont%0d", k));
            chk($sformatf("cont%0d.m1_grant", k), 64'(m1_grant),
                64'(TIMEOUT ? ((k / MAX_HOLD) % 2 == 1) : 1'b0));
        end
        step(1'b0, 1'b1, "cont_drop");
        chk("cont_drop.m1_grant", 64'(m1_grant), 64'd1);

        // Park: nobody requests, master 0 owns an idle bus.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, "park");
            chk("park.m0_grant", 64'(m0_grant), 64'd1);
            chk("park.s_req", 64'(s_req), 64'd0);
        end

        // Randomized traffic with requests held in bursts of random length.
        for (int seg = 0; seg < 150; seg++) begin
            logic r0, r1;
            int len;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                m0_wr = 1'($urandom);
                m1_wr = 1'($urandom);
                m0_address = 8'($urandom);
                m1_address = 8'($urandom);
                m0_dout = $urandom;
                m1_dout = $urandom;
                step(r0, r1, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
